// File: rtl/voice_slot_scheduler.sv
// Time-multiplexes one wavetable ROM path across NUM_VOICES voices, one frame per sample tick.
// Optional ring modulation of odd voices by their even neighbour: define VOICE_RING_MOD_EN.
module voice_slot_scheduler #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned SAMPLE_W   = 24,
  parameter int unsigned ROM_LAT    = 2,
  parameter int unsigned TICK_DIV   = 100
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic [PHASE_W-1:0]            cfg_inc,
  input  logic [2:0]                    cfg_wave,
  input  logic                          cfg_gate,
  input  logic                          cfg_ring,
  output logic [ADDR_W-1:0]             rom_addr,
  output logic [2:0]                    rom_sel,
  input  logic [SAMPLE_W-1:0]           rom_q,
  output logic [SAMPLE_W-1:0]           mix_data,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          tick_overrun
);
  localparam int unsigned VIDX_W = $clog2(NUM_VOICES);
  localparam int unsigned ACC_W  = SAMPLE_W + VIDX_W;
  localparam int unsigned SHIFT  = PHASE_W - ADDR_W;
  localparam int unsigned CNT_W  = $clog2(TICK_DIV);
  localparam int unsigned WAIT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_e;
  state_e state_q, state_d;

  logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [PHASE_W-1:0]  stg_inc_q [NUM_VOICES], stg_inc_d [NUM_VOICES];
  logic [2:0]          stg_wave_q[NUM_VOICES], stg_wave_d[NUM_VOICES];
  logic                stg_gate_q[NUM_VOICES], stg_gate_d[NUM_VOICES];
  logic [PHASE_W-1:0]  act_inc_q [NUM_VOICES], act_inc_d [NUM_VOICES];
  logic [2:0]          act_wave_q[NUM_VOICES], act_wave_d[NUM_VOICES];
  logic                act_gate_q[NUM_VOICES], act_gate_d[NUM_VOICES];
  logic [PHASE_W-1:0]  phase_q   [NUM_VOICES], phase_d   [NUM_VOICES];
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [VIDX_W-1:0]   v_q, v_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [2:0]          rom_sel_q, rom_sel_d;
  logic [SAMPLE_W-1:0] mix_data_q, mix_data_d;
  logic                mix_valid_q, mix_valid_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic [SAMPLE_W-1:0] contrib_c;

`ifdef VOICE_RING_MOD_EN
  localparam int unsigned PROD_W = 2 * SAMPLE_W;
  logic                stg_ring_q[NUM_VOICES], stg_ring_d[NUM_VOICES];
  logic                act_ring_q[NUM_VOICES], act_ring_d[NUM_VOICES];
  logic [SAMPLE_W-1:0] s_even_q, s_even_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
`else
  logic unused_ring_c;
  assign unused_ring_c = cfg_ring;
`endif

  logic              tick_c, last_voice_c, wait_done_c;
  logic [VIDX_W-1:0] v_nxt_c;
  assign tick_c       = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
  assign last_voice_c = (v_q == VIDX_W'(NUM_VOICES - 1));
  assign wait_done_c  = (wait_q == WAIT_W'(ROM_LAT - 1));
  assign v_nxt_c      = v_q + VIDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (tick_c) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT:    if (wait_done_c) state_d = S_CAPTURE;
      S_CAPTURE: state_d = last_voice_c ? S_DONE : S_ISSUE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Contribution of the voice being captured (ring product uses the registered multiply).
`ifdef VOICE_RING_MOD_EN
  assign contrib_c = (v_q[0] && act_ring_q[v_q]) ? prod_q[PROD_W-1:SAMPLE_W] : rom_q;
`else
  assign contrib_c = rom_q;
`endif

  always_comb begin
    tick_cnt_d  = tick_c ? '0 : tick_cnt_q + CNT_W'(1);
    stg_inc_d   = stg_inc_q;
    stg_wave_d  = stg_wave_q;
    stg_gate_d  = stg_gate_q;
    act_inc_d   = act_inc_q;
    act_wave_d  = act_wave_q;
    act_gate_d  = act_gate_q;
    phase_d     = phase_q;
    acc_d       = acc_q;
    v_d         = v_q;
    wait_d      = wait_q;
    rom_addr_d  = rom_addr_q;
    rom_sel_d   = rom_sel_q;
    mix_data_d  = mix_data_q;
    mix_valid_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q | (tick_c && (state_q != S_IDLE));
`ifdef VOICE_RING_MOD_EN
    stg_ring_d  = stg_ring_q;
    act_ring_d  = act_ring_q;
    s_even_d    = s_even_q;
    prod_d      = prod_q;
`endif

    if (cfg_we) begin
      stg_inc_d[cfg_voice]  = cfg_inc;
      stg_wave_d[cfg_voice] = cfg_wave;
      stg_gate_d[cfg_voice] = cfg_gate;
`ifdef VOICE_RING_MOD_EN
      stg_ring_d[cfg_voice] = cfg_ring;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (tick_c) begin
          for (int i = 0; i < int'(NUM_VOICES); i++) begin
            act_inc_d[i]  = stg_inc_q[i];
            act_wave_d[i] = stg_wave_q[i];
            act_gate_d[i] = stg_gate_q[i];
`ifdef VOICE_RING_MOD_EN
            act_ring_d[i] = stg_ring_q[i];
`endif
            if (!act_gate_q[i] && stg_gate_q[i]) phase_d[i] = '0;
          end
          acc_d      = '0;
          v_d        = '0;
          busy_d     = 1'b1;
          rom_addr_d = ADDR_W'(phase_d[0] >> SHIFT);
          rom_sel_d  = stg_wave_q[0];
        end
      end
      S_ISSUE: wait_d = '0;
      S_WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
`ifdef VOICE_RING_MOD_EN
        prod_d = PROD_W'(rom_q) * PROD_W'(s_even_q);
`endif
      end
      S_CAPTURE: begin
        if (act_gate_q[v_q]) begin
          acc_d        = acc_q + ACC_W'(contrib_c);
          phase_d[v_q] = phase_q[v_q] + act_inc_q[v_q];
        end else begin
          phase_d[v_q] = '0;
        end
`ifdef VOICE_RING_MOD_EN
        if (!v_q[0]) s_even_d = act_gate_q[v_q] ? rom_q : '0;
`endif
        // Next voice's address is issued on the same edge that leaves CAPTURE.
        if (last_voice_c) begin
          mix_data_d  = SAMPLE_W'(acc_d >> VIDX_W);
          mix_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          v_d        = v_nxt_c;
          rom_addr_d = ADDR_W'(phase_q[v_nxt_c] >> SHIFT);
          rom_sel_d  = act_wave_q[v_nxt_c];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        stg_inc_q[i]  <= '0;
        stg_wave_q[i] <= '0;
        stg_gate_q[i] <= 1'b0;
        act_inc_q[i]  <= '0;
        act_wave_q[i] <= '0;
        act_gate_q[i] <= 1'b0;
        phase_q[i]    <= '0;
`ifdef VOICE_RING_MOD_EN
        stg_ring_q[i] <= 1'b0;
        act_ring_q[i] <= 1'b0;
`endif
      end
      acc_q       <= '0;
      v_q         <= '0;
      wait_q      <= '0;
      rom_addr_q  <= '0;
      rom_sel_q   <= '0;
      mix_data_q  <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef VOICE_RING_MOD_EN
      s_even_q    <= '0;
      prod_q      <= '0;
`endif
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      stg_inc_q   <= stg_inc_d;
      stg_wave_q  <= stg_wave_d;
      stg_gate_q  <= stg_gate_d;
      act_inc_q   <= act_inc_d;
      act_wave_q  <= act_wave_d;
      act_gate_q  <= act_gate_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      v_q         <= v_d;
      wait_q      <= wait_d;
      rom_addr_q  <= rom_addr_d;
      rom_sel_q   <= rom_sel_d;
      mix_data_q  <= mix_data_d;
      mix_valid_q <= mix_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
`ifdef VOICE_RING_MOD_EN
      stg_ring_q  <= stg_ring_d;
      act_ring_q  <= act_ring_d;
      s_even_q    <= s_even_d;
      prod_q      <= prod_d;
`endif
    end
  end

  assign rom_addr     = rom_addr_q;
  assign rom_sel      = rom_sel_q;
  assign mix_data     = mix_data_q;
  assign mix_valid    = mix_valid_q;
  assign busy         = busy_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_voice_slot_scheduler.sv
// Bench for voice_slot_scheduler: per-frame reference model, randomized config writes,
// plus a second short-tick instance for the overrun behaviour.
module tb_voice_slot_scheduler;
  localparam int unsigned NV    = 8;
  localparam int unsigned PW    = 32;
  localparam int unsigned AW    = 22;
  localparam int unsigned SW    = 24;
  localparam int unsigned RL    = 2;
  localparam int unsigned TD    = 100;
  localparam int unsigned TD2   = 20;
  localparam int unsigned FRAME = NV * (RL + 2) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, cfg_we, cfg_gate, cfg_ring;
  logic [2:0]    cfg_voice, cfg_wave;
  logic [PW-1:0] cfg_inc;
  logic [AW-1:0] rom_addr;
  logic [2:0]    rom_sel;
  logic [SW-1:0] rom_q, mix_data;
  logic          mix_valid, busy, tick_overrun;

  logic          reset2;
  logic [AW-1:0] rom_addr2;
  logic [2:0]    rom_sel2;
  logic [SW-1:0] mix_data2;
  logic          mix_valid2, busy2, tick_overrun2;

  int       rom_mode;
  logic [SW-1:0] rom_const;
  int       n_tests = 0;
  int       n_fail  = 0;
  longint   cyc     = 0;

  function automatic logic [SW-1:0] rom_fn(input logic [AW-1:0] a, input logic [2:0] s,
                                            input int mode, input logic [SW-1:0] k);
    logic [SW-1:0] t;
    t = {2'b00, a};
    case (mode)
      0:       rom_fn = t + 24'd5;
      1:       rom_fn = k;
      default: rom_fn = (t * 24'd40503) ^ ({21'd0, s} * 24'h1357b1) ^ 24'ha5a5a5;
    endcase
  endfunction

  assign rom_q = rom_fn(rom_addr, rom_sel, rom_mode, rom_const);

  voice_slot_scheduler dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_inc(cfg_inc),
    .cfg_wave(cfg_wave), .cfg_gate(cfg_gate), .cfg_ring(cfg_ring),
    .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_q(rom_q),
    .mix_data(mix_data), .mix_valid(mix_valid), .busy(busy), .tick_overrun(tick_overrun)
  );

  voice_slot_scheduler #(.TICK_DIV(TD2)) dut2 (
    .clk(clk), .reset(reset2), .cfg_we(1'b0), .cfg_voice(3'd0), .cfg_inc(32'd0),
    .cfg_wave(3'd0), .cfg_gate(1'b0), .cfg_ring(1'b0),
    .rom_addr(rom_addr2), .rom_sel(rom_sel2), .rom_q(24'h123456),
    .mix_data(mix_data2), .mix_valid(mix_valid2), .busy(busy2), .tick_overrun(tick_overrun2)
  );

  // Reference model: staging/active config per voice, phases, expected frame results.
  logic [PW-1:0] m_sinc[NV], m_ainc[NV], m_phase[NV];
  logic [2:0]    m_swave[NV], m_awave[NV];
  logic          m_sgate[NV], m_agate[NV], m_sring[NV], m_aring[NV];
  logic [AW-1:0] e_addr[NV];
  logic [2:0]    e_sel[NV];
  logic [SW-1:0] e_mix;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NV); i++) begin
      m_sinc[i] = '0; m_ainc[i] = '0; m_phase[i] = '0;
      m_swave[i] = '0; m_awave[i] = '0;
      m_sgate[i] = 1'b0; m_agate[i] = 1'b0; m_sring[i] = 1'b0; m_aring[i] = 1'b0;
    end
  endtask

  task automatic model_frame();
    longint unsigned acc;
    logic [SW-1:0]   s, s_even, contrib;
    logic [2*SW-1:0] p;
    acc = 0;
    s_even = '0;
    for (int v = 0; v < int'(NV); v++) begin
      if (!m_agate[v] && m_sgate[v]) m_phase[v] = '0;
      m_ainc[v] = m_sinc[v]; m_awave[v] = m_swave[v];
      m_agate[v] = m_sgate[v]; m_aring[v] = m_sring[v];
    end
    for (int v = 0; v < int'(NV); v++) begin
      e_addr[v] = AW'(m_phase[v] >> (PW - AW));
      e_sel[v]  = m_awave[v];
      s = rom_fn(e_addr[v], e_sel[v], rom_mode, rom_const);
      if (m_agate[v]) begin
        contrib = s;
`ifdef VOICE_RING_MOD_EN
        if ((v % 2 == 1) && m_aring[v]) begin
          p = {24'd0, s} * {24'd0, s_even};
          contrib = p[2*SW-1:SW];
        end
`endif
        acc += contrib;
        m_phase[v] = m_phase[v] + m_ainc[v];
      end else begin
        m_phase[v] = '0;
      end
      if (v % 2 == 0) s_even = m_agate[v] ? s : '0;
    end
    p = '0;
    e_mix = SW'(acc / NV);
  endtask

  task automatic cfg_set(input int v, input logic [PW-1:0] inc, input logic [2:0] wave,
                         input logic gate, input logic ring);
    cfg_we = 1'b1; cfg_voice = 3'(v); cfg_inc = inc; cfg_wave = wave;
    cfg_gate = gate; cfg_ring = ring;
    m_sinc[v] = inc; m_swave[v] = wave; m_sgate[v] = gate; m_sring[v] = ring;
  endtask

  task automatic write_now(input int v, input logic [PW-1:0] inc, input logic [2:0] wave,
                           input logic gate, input logic ring);
    cfg_set(v, inc, wave, gate, ring);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic rand_write();
    cfg_set(int'($urandom_range(0, NV - 1)), $urandom, 3'($urandom_range(0, 4)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic goto_tick();
    while (cyc % TD != TD - 1) step();
  endtask

  // Runs one frame from its tick; optional write in the tick cycle and one mid-frame write.
  task automatic run_frame(input bit tw, input int tw_v, input logic [PW-1:0] tw_inc,
                           input logic [2:0] tw_wave, input logic tw_gate, input bit mid_w);
    int v;
    goto_tick();
    check("overrun_idle", tick_overrun, 1'b0);
    model_frame();
    if (tw) cfg_set(tw_v, tw_inc, tw_wave, tw_gate, 1'b0);
    for (int k = 1; k <= int'(FRAME); k++) begin
      step();
      cfg_we = 1'b0;
      if (mid_w && k == 10) rand_write();
      if (k < int'(FRAME) && (k - 1) % int'(RL + 2) == 0) begin
        v = (k - 1) / int'(RL + 2);
        check($sformatf("rom_addr_v%0d", v), rom_addr, e_addr[v]);
        check($sformatf("rom_sel_v%0d", v), rom_sel, e_sel[v]);
        check("busy_frame", busy, 1'b1);
      end
      if (k == int'(FRAME) - 1) check("mix_valid_early", mix_valid, 1'b0);
    end
    check("mix_valid", mix_valid, 1'b1);
    check("mix_data", mix_data, e_mix);
    check("busy_done", busy, 1'b0);
    step();
    check("mix_valid_pulse", mix_valid, 1'b0);
    check("mix_data_hold", mix_data, e_mix);
  endtask

  initial begin
    int n_valid2;
    reset = 1'b1; reset2 = 1'b1;
    cfg_we = 1'b0; cfg_voice = '0; cfg_inc = '0; cfg_wave = '0; cfg_gate = 1'b0; cfg_ring = 1'b0;
    rom_mode = 0; rom_const = '0;
    model_reset();
    repeat (3) step();
    check("rst_mix_data", mix_data, 24'd0);
    check("rst_mix_valid", mix_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", tick_overrun, 1'b0);
    check("rst_rom_addr", rom_addr, 22'd0);
    check("rst_rom_sel", rom_sel, 3'd0);
    reset = 1'b0;
    cyc = 0;

    // Single voice, ROM returns address+5, then a forced half-scale sample.
    write_now(0, 32'd1024, 3'd0, 1'b1, 1'b0);
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);
    rom_mode = 1; rom_const = 24'h800000;
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);
    check("plan_mix_half", mix_data, 24'h100000);

    // All voices gated at full scale, distinct waves.
    rom_const = 24'hFFFFFF;
    for (int v = 0; v < int'(NV); v++) write_now(v, $urandom, 3'(v % 5), 1'b1, 1'b0);
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);
    check("plan_mix_full", mix_data, 24'hFFFFFF);

    // Tick-coincident writes and gate 1->0->1 retrigger on voice 2.
    rom_mode = 2;
    write_now(2, 32'h12345678, 3'd3, 1'b1, 1'b0);
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);
    run_frame(1'b1, 2, 32'h00ABCDEF, 3'd1, 1'b0, 1'b0);
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);
    write_now(2, 32'h00001000, 3'd4, 1'b1, 1'b0);
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);

    // Voice 3 phase wrap through 0xFFFFFC00 + 0x800.
    write_now(3, 32'd0, 3'd2, 1'b0, 1'b0);
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);
    write_now(3, 32'hFFFFFC00, 3'd2, 1'b1, 1'b0);
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);
    write_now(3, 32'h00000800, 3'd2, 1'b1, 1'b0);
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);
    check("wrap_model_phase", 64'(m_phase[3]), 64'h0C00);

`ifdef VOICE_RING_MOD_EN
    rom_mode = 1; rom_const = 24'h800000;
    for (int v = 0; v < int'(NV); v++) write_now(v, '0, 3'd0, 1'b0, 1'b0);
    write_now(0, 32'd4096, 3'd0, 1'b1, 1'b0);
    write_now(1, 32'd4096, 3'd1, 1'b1, 1'b1);
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);
    check("plan_ring_mix", mix_data, 24'h180000);
    rom_mode = 2;
`endif

    // Randomized frames with writes before, at and during the tick.
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 4)) begin
        rand_write();
        step();
        cfg_we = 1'b0;
      end
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)), $urandom,
                3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset mid-frame aborts the frame and clears everything.
    goto_tick();
    repeat (10) step();
    reset = 1'b1;
    step();
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", mix_valid, 1'b0);
    check("midrst_mix", mix_data, 24'd0);
    check("midrst_addr", rom_addr, 22'd0);
    check("midrst_sel", rom_sel, 3'd0);
    reset = 1'b0;
    cyc = 0;
    model_reset();
    write_now(5, 32'h00C00000, 3'd3, 1'b1, 1'b0);
    run_frame(1'b0, 0, '0, '0, 1'b0, 1'b0);

    // Short tick period on the second instance: overrun is sticky until reset.
    check("t2_rst_overrun", tick_overrun2, 1'b0);
    check("t2_rst_busy", busy2, 1'b0);
    check("t2_rst_addr", rom_addr2, 22'd0);
    check("t2_rst_sel", rom_sel2, 3'd0);
    reset2 = 1'b0;
    n_valid2 = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (c == 39) check("t2_overrun_before", tick_overrun2, 1'b0);
      if (c == 40) check("t2_overrun_set", tick_overrun2, 1'b1);
      if (c == 52) begin
        check("t2_valid_52", mix_valid2, 1'b1);
        check("t2_mix_off", mix_data2, 24'd0);
      end
      if (mix_valid2) n_valid2++;
    end
    check("t2_overrun_sticky", tick_overrun2, 1'b1);
    check("t2_frames", 64'(n_valid2), 64'd2);
    reset2 = 1'b1;
    step();
    check("t2_overrun_cleared", tick_overrun2, 1'b0);
    check("t2_busy_cleared", busy2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
